mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port synchronous memory between the instruction-fetch requester and the load/store requester of the RV32I core.
- Sequences every access as grant -> issue -> fixed-latency wait -> response, with exactly one transaction outstanding at a time.
- Load/store has priority; a starvation limiter guarantees fetch progress.
- Sits between the program counter/control path and the unified memory array.

Parameters:
ADDR_WIDTH, 10, width of all address buses
DATA_WIDTH, 32, width of all data buses
MEM_LATENCY, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..7
STARVE_LIMIT, 4, max consecutive load/store grants while if_req is pending; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_WIDTH  fetch address; stable while if_req high
if_gnt  out  1  fetch request accepted (single-cycle pulse)
if_rvalid  out  1  fetch data valid (single-cycle pulse)
if_rdata  out  DATA_WIDTH  fetched instruction
ls_req  in  1  load/store request; held until ls_gnt
ls_we  in  1  1 = store, 0 = load
ls_addr  in  ADDR_WIDTH  load/store address
ls_wdata  in  DATA_WIDTH  store data
ls_gnt  out  1  load/store request accepted (single-cycle pulse)
ls_rvalid  out  1  load data valid or store complete (single-cycle pulse)
ls_rdata  out  DATA_WIDTH  load data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data
busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE; wait counter=0; starve counter=0; owner=fetch. All outputs are 0: gnt, rvalid, mem_en, mem_we, mem_addr, mem_wdata, rdata register, busy. An in-flight transaction is dropped with no rvalid; requesters re-issue after reset.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, arbitration:
  - Winner = ls if ls_req, unless if_req && starve counter == STARVE_LIMIT, in which case fetch wins.
  - The winner's gnt is a combinational pulse in this cycle, asserted only in IDLE and never to both requesters.
  - On the grant edge, the winner's addr/we/wdata are latched (fetch uses we=0, wdata=0), owner is recorded, and the FSM goes to ISSUE.
  - No request: stay in IDLE.
- ISSUE: mem_en=1 and mem_we=latched we for exactly this one cycle. mem_addr/mem_wdata hold the latched values until the next grant. Wait counter loads MEM_LATENCY; go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle the counter equals 1, mem_rdata is valid and is registered into the shared rdata register; the FSM goes to IDLE.
  - For stores, rdata is loaded with 0.
- Response: in the first IDLE cycle after WAIT, the owner's rvalid=1 for one cycle. A new grant may be issued in that same cycle (back-to-back).
- if_rdata and ls_rdata are both driven from the shared rdata register and are meaningful only with their rvalid. The value holds until the next capture.
- Latency: grant at cycle 0, mem_en at cycle 1, rvalid at cycle 2+MEM_LATENCY. Peak throughput is one access per 2+MEM_LATENCY cycles.
- Starve counter (4 bits, saturating at STARVE_LIMIT):
  - +1 on an ls grant while if_req=1.
  - Cleared on any fetch grant.
  - Cleared on an ls grant while if_req=0.
- Request changes outside IDLE are ignored; deasserting req before gnt withdraws it legally.
- busy=1 in ISSUE and WAIT.

Test Plan:
- Reset mid-WAIT: fetch granted at 0x010, rst_n low during WAIT -> all outputs 0 immediately, no if_rvalid, busy=0; after release an idle bus keeps mem_en=0.
- Single fetch, MEM_LATENCY=1: if_req at if_addr=0x004, memory word 0x00500093 -> if_gnt cycle 0, mem_en=1/mem_we=0/mem_addr=0x004 cycle 1, if_rvalid=1 with if_rdata=0x00500093 cycle 3.
- Store then load, same address: ls_we=1, ls_addr=0x020, ls_wdata=0xDEADBEEF -> mem_we=1 cycle 1, ls_rvalid cycle 3 with ls_rdata=0. Then a load of 0x020 -> ls_rdata=0xDEADBEEF.
- Simultaneous requests: if_req and ls_req in the same IDLE cycle -> ls_gnt=1, if_gnt=0. Fetch is granted on the ls_rvalid cycle when ls_req is low.
- Starvation, STARVE_LIMIT=4: if_req and ls_req held high continuously -> exactly 4 ls grants, then an if_gnt, then ls resumes. The grant pattern repeats 4:1 and if_gnt and ls_gnt are never high together.
- MEM_LATENCY=3: single load -> ls_rvalid exactly 5 cycles after ls_gnt, busy high for 4 cycles, back-to-back request granted on the rvalid cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request, response and memory-side signals shared between the fetch unit,
// the load/store unit, the arbiter and the unified memory array.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  ls_req;
  logic                  ls_we;
  logic [ADDR_WIDTH-1:0] ls_addr;
  logic [DATA_WIDTH-1:0] ls_wdata;
  logic                  ls_gnt;
  logic                  ls_rvalid;
  logic [DATA_WIDTH-1:0] ls_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// One transaction in flight: grant -> issue -> fixed-latency wait -> response.
//
// state | meaning
// IDLE  | arbitrate; pulse gnt to winner; owner's rvalid after a WAIT
// ISSUE | mem_en (and mem_we for stores) for one cycle, load wait counter
// WAIT  | count down memory latency, capture mem_rdata when counter is 1
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           rst_n,
  mem_arbiter_if.slave  bus
);

  localparam logic [2:0] LAT  = 3'(MEM_LATENCY);
  localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [2:0]            wait_cnt;
  logic [3:0]            starve_cnt;
  logic                  owner_ls;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  we_q;
  logic                  if_rvalid_q;
  logic                  ls_rvalid_q;
  logic                  grant_if;
  logic                  grant_ls;

  // Load/store wins unless fetch has been passed over STARVE_LIMIT times.
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_ls  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.if_req && (!bus.ls_req || starve_cnt == SLIM)) begin
          grant_if = 1'b1;
        end else if (bus.ls_req) begin
          grant_ls = 1'b1;
        end
        if (grant_if || grant_ls) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (wait_cnt == 3'd1) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= 3'd0;
      starve_cnt  <= 4'd0;
      owner_ls    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      rdata_q     <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
    end else begin
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;

      if (grant_if) begin
        addr_q     <= bus.if_addr;
        wdata_q    <= '0;
        we_q       <= 1'b0;
        owner_ls   <= 1'b0;
        starve_cnt <= 4'd0;
      end else if (grant_ls) begin
        addr_q   <= bus.ls_addr;
        wdata_q  <= bus.ls_wdata;
        we_q     <= bus.ls_we;
        owner_ls <= 1'b1;
        if (!bus.if_req) begin
          starve_cnt <= 4'd0;
        end else if (starve_cnt < SLIM) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end

      if (state == ISSUE) begin
        wait_cnt <= LAT;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 3'd1;
        if (wait_cnt == 3'd1) begin
          rdata_q     <= we_q ? '0 : bus.mem_rdata;
          if_rvalid_q <= !owner_ls;
          ls_rvalid_q <= owner_ls;
        end
      end
    end
  end

  assign bus.if_gnt    = grant_if;
  assign bus.ls_gnt    = grant_ls;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.ls_rvalid = ls_rvalid_q;
  assign bus.if_rdata  = rdata_q;
  assign bus.ls_rdata  = rdata_q;
  assign bus.mem_en    = (state == ISSUE);
  assign bus.mem_we    = (state == ISSUE) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LATENCY=1 and one at 3,
// each with a small synchronous memory model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus1 ();
  mem_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus3 ();

  mem_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  mem_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  // Memory models: fixed words at 0x004 and 0x030, writable array elsewhere.
  logic [31:0] mem1 [0:1023];
  logic [31:0] pipe1 = 32'd0;
  logic [31:0] p3a = 32'd0, p3b = 32'd0, p3c = 32'd0;

  function automatic logic [31:0] rom_word(input logic [9:0] a, input logic [31:0] dflt);
    if (a == 10'h004) return 32'h00500093;
    if (a == 10'h030) return 32'h12345678;
    return dflt;
  endfunction

  always @(posedge clk) begin
    if (bus1.mem_en) begin
      if (bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_wdata;
      pipe1 <= rom_word(bus1.mem_addr, mem1[bus1.mem_addr]);
    end
  end
  assign bus1.mem_rdata = pipe1;

  always @(posedge clk) begin
    p3a <= bus3.mem_en ? rom_word(bus3.mem_addr, 32'hA5A5_0000) : 32'd0;
    p3b <= p3a;
    p3c <= p3b;
  end
  assign bus3.mem_rdata = p3c;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  initial begin
    int k;
    int busy_n;
    int early_rv;
    int cnt_rv;
    int cnt_en;

    rst_n = 1'b0;
    bus1.if_req = 0; bus1.if_addr = '0; bus1.ls_req = 0; bus1.ls_we = 0;
    bus1.ls_addr = '0; bus1.ls_wdata = '0;
    bus3.if_req = 0; bus3.if_addr = '0; bus3.ls_req = 0; bus3.ls_we = 0;
    bus3.ls_addr = '0; bus3.ls_wdata = '0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_busy",    bus1.busy, 0);
    check("rst_mem_en",  bus1.mem_en, 0);
    check("rst_mem_we",  bus1.mem_we, 0);
    check("rst_mem_addr", bus1.mem_addr, 0);
    check("rst_rdata",   bus1.if_rdata, 0);
    check("rst_rvalid",  {bus1.if_rvalid, bus1.ls_rvalid}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single fetch, latency 1
    @(negedge clk);
    bus1.if_req = 1; bus1.if_addr = 10'h004;
    #1;
    check("fetch_gnt", bus1.if_gnt, 1);
    check("fetch_ls_gnt", bus1.ls_gnt, 0);
    @(negedge clk);
    bus1.if_req = 0;
    #1;
    check("fetch_mem_en", bus1.mem_en, 1);
    check("fetch_mem_we", bus1.mem_we, 0);
    check("fetch_mem_addr", bus1.mem_addr, 32'h004);
    check("fetch_busy", bus1.busy, 1);
    @(negedge clk); #1;
    check("fetch_rvalid_c2", bus1.if_rvalid, 0);
    @(negedge clk); #1;
    check("fetch_rvalid", bus1.if_rvalid, 1);
    check("fetch_rdata", bus1.if_rdata, 32'h00500093);
    check("fetch_idle", bus1.busy, 0);

    // Store then load at 0x020
    @(negedge clk);
    bus1.ls_req = 1; bus1.ls_we = 1; bus1.ls_addr = 10'h020; bus1.ls_wdata = 32'hDEADBEEF;
    #1;
    check("st_gnt", bus1.ls_gnt, 1);
    @(negedge clk);
    bus1.ls_req = 0; bus1.ls_we = 0;
    #1;
    check("st_mem_we", bus1.mem_we, 1);
    check("st_mem_wdata", bus1.mem_wdata, 32'hDEADBEEF);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("st_rvalid", bus1.ls_rvalid, 1);
    check("st_rdata", bus1.ls_rdata, 0);
    @(negedge clk);
    bus1.ls_req = 1; bus1.ls_addr = 10'h020;
    #1;
    check("ld_gnt", bus1.ls_gnt, 1);
    @(negedge clk);
    bus1.ls_req = 0;
    #1;
    check("ld_mem_we", bus1.mem_we, 0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("ld_rvalid", bus1.ls_rvalid, 1);
    check("ld_rdata", bus1.ls_rdata, 32'hDEADBEEF);

    // Simultaneous requests: load/store first, fetch on the rvalid cycle
    @(negedge clk);
    bus1.if_req = 1; bus1.if_addr = 10'h004;
    bus1.ls_req = 1; bus1.ls_addr = 10'h020;
    #1;
    check("sim_ls_gnt", bus1.ls_gnt, 1);
    check("sim_if_gnt", bus1.if_gnt, 0);
    @(negedge clk);
    bus1.ls_req = 0;
    #1;
    check("sim_if_gnt_issue", bus1.if_gnt, 0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("sim_ls_rvalid", bus1.ls_rvalid, 1);
    check("sim_ls_rdata", bus1.ls_rdata, 32'hDEADBEEF);
    check("sim_b2b_if_gnt", bus1.if_gnt, 1);
    @(negedge clk);
    bus1.if_req = 0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("sim_if_rvalid", bus1.if_rvalid, 1);
    check("sim_if_rdata", bus1.if_rdata, 32'h00500093);

    // Starvation limiter: grant pattern L L L L F repeating
    k = 0;
    for (int c = 0; c < 60 && k < 10; c++) begin
      @(negedge clk);
      bus1.if_req = 1; bus1.ls_req = 1; bus1.ls_we = 0;
      #1;
      if (bus1.if_gnt || bus1.ls_gnt) begin
        check("starve_excl", {31'd0, bus1.if_gnt & bus1.ls_gnt}, 0);
        check($sformatf("starve_g%0d", k), bus1.if_gnt, (k % 5 == 4) ? 32'd1 : 32'd0);
        k++;
      end
    end
    check("starve_grants", k, 10);
    @(negedge clk);
    bus1.if_req = 0; bus1.ls_req = 0;
    repeat (4) @(negedge clk);

    // Latency 3: single load, busy window, back-to-back fetch on rvalid cycle
    @(negedge clk);
    bus3.ls_req = 1; bus3.ls_addr = 10'h030;
    #1;
    check("l3_ls_gnt", bus3.ls_gnt, 1);
    busy_n = 0;
    early_rv = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) bus3.ls_req = 0;
      #1;
      busy_n += int'(bus3.busy);
      early_rv += int'(bus3.ls_rvalid);
    end
    check("l3_busy_cycles", busy_n, 4);
    check("l3_early_rvalid", early_rv, 0);
    @(negedge clk);
    bus3.if_req = 1; bus3.if_addr = 10'h010;
    #1;
    check("l3_ls_rvalid", bus3.ls_rvalid, 1);
    check("l3_ls_rdata", bus3.ls_rdata, 32'h12345678);
    check("l3_b2b_if_gnt", bus3.if_gnt, 1);

    // Reset during WAIT of the fetch at 0x010
    @(negedge clk);
    bus3.if_req = 0;
    #1;
    check("rw_mem_addr", bus3.mem_addr, 32'h010);
    @(negedge clk); #1;
    check("rw_busy_wait", bus3.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rw_busy", bus3.busy, 0);
    check("rw_mem_en", bus3.mem_en, 0);
    check("rw_mem_addr_clr", bus3.mem_addr, 0);
    check("rw_if_rvalid", bus3.if_rvalid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_rv = 0;
    cnt_en = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      cnt_rv += int'(bus3.if_rvalid);
      cnt_en += int'(bus3.mem_en);
    end
    check("rw_no_rvalid", cnt_rv, 0);
    check("rw_idle_mem_en", cnt_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
